johnson_phase_monitor: RTL

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

---
 rtl/johnson_phase_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/johnson_phase_monitor.sv
// Decodes a 4-bit Johnson counter code and reports its one-hot phase and index.
// Tracks successor transitions to declare lock, and flags and counts illegal codes and skips.
module johnson_phase_monitor #(
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [3:0] q,
   input  logic       clr_err,
   output logic [7:0] phase,
   output logic [2:0] phase_idx,
   output logic       valid,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      UNLOCKED,
      TRACK,
      LOCKED
   } state_t;

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

   state_t     state;
   logic [2:0] prev_idx;
   logic [3:0] run;
   logic [3:0] run_inc;

   logic       legal;
   logic [2:0] idx;
   logic       succ;
   logic       same;
   logic       error_now;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      legal = 1'b1;
      idx   = 3'd0;
      case (q)
         4'b0000: idx = 3'd0;
         4'b0001: idx = 3'd1;
         4'b0011: idx = 3'd2;
         4'b0111: idx = 3'd3;
         4'b1111: idx = 3'd4;
         4'b1110: idx = 3'd5;
         4'b1100: idx = 3'd6;
         4'b1000: idx = 3'd7;
         default: legal = 1'b0;
      endcase
   end

   // 3-bit compare makes 7 -> 0 wrap naturally.
   assign succ      = (idx == 3'(prev_idx + 3'd1));
   assign same      = (idx == prev_idx);
   assign run_inc   = run + 4'd1;
   assign error_now = en && (!legal || (state == LOCKED && !succ && !same));

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= UNLOCKED;
         prev_idx  <= 3'd0;
         run       <= 4'd0;
         phase     <= 8'h00;
         phase_idx <= 3'd0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         err <= error_now;

         // Clear wins over the count, but an error in the same cycle is still counted once.
         if (clr_err)
            err_cnt <= {7'd0, error_now};
         else if (error_now && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;

         if (en) begin
            if (!legal) begin
               valid  <= 1'b0;
               state  <= UNLOCKED;
               locked <= 1'b0;
               run    <= 4'd0;
            end else begin
               valid     <= 1'b1;
               phase     <= 8'd1 << idx;
               phase_idx <= idx;
               prev_idx  <= idx;
               case (state)
                  UNLOCKED: begin
                     run   <= 4'd0;
                     state <= TRACK;
                  end
                  TRACK: begin
                     if (succ) begin
                        run <= run_inc;
                        if (run_inc == LOCK_RUN) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else if (!same) begin
                        run <= 4'd0;
                     end
                  end
                  LOCKED: begin
                     if (!succ && !same) begin
                        run    <= 4'd0;
                        state  <= TRACK;
                        locked <= 1'b0;
                     end
                  end
                  default: begin
                     state  <= UNLOCKED;
                     locked <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule
